// File: rtl/half_adder_pkg.sv
// Shared definitions for the half adder leaf and the datapaths built on it.
// The result struct is sized for the widest supported operand; users that
// need a narrower view slice the low bits of sum at the use site.
package half_adder_pkg;

    localparam int HA_MAX_WIDTH = 64;

    typedef struct packed {
        logic                    cout;
        logic [HA_MAX_WIDTH-1:0] sum;
    } ha_result_t;

    // Unsigned add of two width-bit operands with no carry-in; the carry-out
    // is the bit just above the operand width and sum is masked to width bits.
    function automatic ha_result_t ha_add(input logic [HA_MAX_WIDTH-1:0] a,
                                          input logic [HA_MAX_WIDTH-1:0] b,
                                          input int unsigned             width);
        logic [HA_MAX_WIDTH:0]   full;
        logic [HA_MAX_WIDTH-1:0] mask;
        ha_result_t              res;
        full = {1'b0, a} + {1'b0, b};
        if (width >= HA_MAX_WIDTH) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        res.sum  = full[HA_MAX_WIDTH-1:0] & mask;
        res.cout = full[width];
        return res;
    endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder cell: the leaf reused by the wider adder
// and by the adder/subtractor datapaths.
module half_adder_cell (
    input  logic x_i,
    input  logic y_i,
    output logic s_o,
    output logic c_o
);

    // Sum is the XOR of the two bits, carry is their AND.
    always_comb begin
        s_o = x_i ^ y_i;
        c_o = x_i & y_i;
    end

endmodule

// File: rtl/half_adder.sv
// Registered, width-parameterised half adder: {cout, sum} = a + b with no
// carry-in, one register stage, qualified by out_valid.
// Optional feature macro: HALF_ADDER_CARRY_CNT_EN adds carry_count, a
// saturating count of accepted operations that produced a carry-out.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef HALF_ADDER_CARRY_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_count
`endif
);

    logic             sumBit0;
    logic             carryBit0;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Out-of-range parameters instantiate a module that does not exist, so a
    // bad configuration stops at elaboration instead of building silently.
    generate
        if (WIDTH < 1 || WIDTH > HA_MAX_WIDTH || CNT_W < 1) begin : gBadParam
            half_adder_illegal_parameter uBadParam ();
        end
    endgenerate

    half_adder_cell uCell0 (
        .x_i (a[0]),
        .y_i (b[0]),
        .s_o (sumBit0),
        .c_o (carryBit0)
    );

    // Bit 0 comes from the cell; the upper bits add with the cell's carry
    // rippling in, and the top bit of that partial sum is the carry-out.
    generate
        if (WIDTH == 1) begin : gOneBit
            assign sum_d  = sumBit0;
            assign cout_d = carryBit0;
        end else begin : gWide
            logic [WIDTH-1:0] upper;
            assign upper  = {1'b0, a[WIDTH-1:1]} + {1'b0, b[WIDTH-1:1]}
                          + WIDTH'(carryBit0);
            assign sum_d  = {upper[WIDTH-2:0], sumBit0};
            assign cout_d = upper[WIDTH-1];
        end
    endgenerate

    // Result register: loads only on accepted operations so idle cycles
    // (where a/b may be X) leave sum/cout untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step on an accepted carry, stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (in_valid && cout_d && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register, updating on the same edge as cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign carry_count = count_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: a WIDTH=1 and a WIDTH=8 instance share
// clock and reset; expected results are queued when an operation is driven
// and popped when the registered output appears.
module tb_half_adder;
    import half_adder_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;

    logic       v1 = 1'b0;
    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic       ov1;
    logic       s1;
    logic       c1;

    logic       v8 = 1'b0;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic       ov8;
    logic [7:0] s8;
    logic       c8;

`ifdef HALF_ADDER_CARRY_CNT_EN
    logic [15:0] cc1;
    logic [1:0]  cc8;
`endif

    int total = 0;
    int bad   = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];

    always #10 clk = ~clk;

    half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .out_valid (ov1),
        .sum       (s1),
        .cout      (c1)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_count (cc1)
`endif
    );

    half_adder #(.WIDTH(8), .CNT_W(2)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .sum       (s8),
        .cout      (c8)
`ifdef HALF_ADDER_CARRY_CNT_EN
        ,
        .carry_count (cc8)
`endif
    );

    // Drive one cycle on the 1-bit instance; queue the expected {cout,sum}.
    task automatic drive1(input logic v, input logic a, input logic b, input logic [1:0] expRes);
        @(negedge clk);
        v1 = v;
        a1 = a;
        b1 = b;
        @(posedge clk);
        if (v === 1'b1) q1.push_back(expRes);
        #1;
    endtask

    // Drive one cycle on the 8-bit instance; queue the expected {cout,sum}.
    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [8:0] expRes);
        @(negedge clk);
        v8 = v;
        a8 = a;
        b8 = b;
        @(posedge clk);
        if (v === 1'b1) q8.push_back(expRes);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ov1, c1, s1} !== 3'b000) begin
            bad++;
            $display("FAIL reset_w1: got ov/c/s=%b want 000", {ov1, c1, s1});
        end
        total++;
        if ({ov8, c8, s8} !== 10'h000) begin
            bad++;
            $display("FAIL reset_w8: got ov/c/s=%h want 000", {ov8, c8, s8});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_width1();
        logic [1:0] tbl [4];
        logic [1:0] expRes;
        tbl[0] = 2'b00;
        tbl[1] = 2'b01;
        tbl[2] = 2'b01;
        tbl[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            drive1(1'b1, i[1], i[0], tbl[i]);
            total++;
            if (ov1 !== 1'b1) begin
                bad++;
                $display("FAIL w1_valid[%0d]: got %b want 1", i, ov1);
            end
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL w1_queue[%0d]: got empty want entry", i);
            end else begin
                expRes = q1.pop_front();
                if ({c1, s1} !== expRes) begin
                    bad++;
                    $display("FAIL w1_result[%0d]: got c,s=%b want %b", i, {c1, s1}, expRes);
                end
            end
        end
    endtask

    task automatic test_idle_hold();
        for (int k = 0; k < 3; k++) begin
            drive1(1'b0, (k == 1) ? 1'bx : k[0], ~k[0], 2'b00);
            total++;
            if (ov1 !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid[%0d]: got %b want 0", k, ov1);
            end
            total++;
            if ({c1, s1} !== 2'b10) begin
                bad++;
                $display("FAIL idle_hold[%0d]: got c,s=%b want 10", k, {c1, s1});
            end
        end
    endtask

    task automatic test_width8();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [8:0] ve [3];
        logic [8:0] expRes;
        va[0] = 8'hFF; vb[0] = 8'h01; ve[0] = 9'h100;
        va[1] = 8'hFF; vb[1] = 8'hFF; ve[1] = 9'h1FE;
        va[2] = 8'h12; vb[2] = 8'h34; ve[2] = 9'h046;
        for (int i = 0; i < 3; i++) begin
            drive8(1'b1, va[i], vb[i], ve[i]);
            total++;
            if (ov8 !== 1'b1 || q8.size() == 0) begin
                bad++;
                $display("FAIL w8_valid[%0d]: got ov=%b q=%0d want ov=1", i, ov8, q8.size());
            end else begin
                expRes = q8.pop_front();
                if ({c8, s8} !== expRes) begin
                    bad++;
                    $display("FAIL w8_result[%0d]: got %h want %h", i, {c8, s8}, expRes);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] expRes;
        drive8(1'b1, 8'h55, 8'hAA, 9'h0FF);
        total++;
        if (ov8 !== 1'b1 || q8.size() == 0) begin
            bad++;
            $display("FAIL arst_pre: got ov=%b want 1", ov8);
        end else begin
            expRes = q8.pop_front();
            if ({c8, s8} !== expRes) begin
                bad++;
                $display("FAIL arst_pre_result: got %h want %h", {c8, s8}, expRes);
            end
        end
        #4;
        rst_n = 1'b0;
        v8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'hFF;
        #1;
        total++;
        if ({ov8, c8, s8} !== 10'h000) begin
            bad++;
            $display("FAIL arst_immediate: got %h want 000", {ov8, c8, s8});
        end
        @(posedge clk);
        #1;
        total++;
        if ({ov8, c8, s8} !== 10'h000) begin
            bad++;
            $display("FAIL arst_discard: got %h want 000", {ov8, c8, s8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        v8 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({ov8, c8, s8} !== 10'h000) begin
            bad++;
            $display("FAIL arst_idle_after: got %h want 000", {ov8, c8, s8});
        end
        drive8(1'b1, 8'h12, 8'h34, 9'h046);
        total++;
        if (ov8 !== 1'b1 || q8.size() == 0) begin
            bad++;
            $display("FAIL arst_first_op: got ov=%b want 1", ov8);
        end else begin
            expRes = q8.pop_front();
            if ({c8, s8} !== expRes) begin
                bad++;
                $display("FAIL arst_first_result: got %h want %h", {c8, s8}, expRes);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  held;
        logic [8:0]  expRes;
        logic        v;
        logic [7:0]  a;
        logic [7:0]  b;
        ha_result_t  r;
        held = 9'h046;
        for (int n = 0; n < 1000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (n % 4 == 0) begin
                a = 8'hFF;
                b = (n % 8 == 0) ? 8'hFF : 8'h01;
            end
            r = ha_add(64'(a), 64'(b), 8);
            drive8(v, (v ? a : 8'hxx), b, {r.cout, r.sum[7:0]});
            total++;
            if (ov8 !== v) begin
                bad++;
                $display("FAIL b2b_valid[%0d]: got %b want %b", n, ov8, v);
            end else if (v) begin
                if (q8.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_queue[%0d]: got empty want entry", n);
                end else begin
                    expRes = q8.pop_front();
                    held = expRes;
                    if ({c8, s8} !== expRes) begin
                        bad++;
                        $display("FAIL b2b_result[%0d]: got %h want %h", n, {c8, s8}, expRes);
                    end
                end
            end else if ({c8, s8} !== held) begin
                bad++;
                $display("FAIL b2b_hold[%0d]: got %h want %h", n, {c8, s8}, held);
            end
        end
    endtask

`ifdef HALF_ADDER_CARRY_CNT_EN
    task automatic test_carry_count();
        logic [7:0] oa [8];
        logic [7:0] ob [8];
        logic       ov [8];
        logic [1:0] oc [8];
        logic [8:0] expRes;
        ha_result_t r;
        oa[0] = 8'hFF; ob[0] = 8'h01; ov[0] = 1'b1; oc[0] = 2'd1;
        oa[1] = 8'h12; ob[1] = 8'h34; ov[1] = 1'b1; oc[1] = 2'd1;
        oa[2] = 8'hFF; ob[2] = 8'hFF; ov[2] = 1'b0; oc[2] = 2'd1;
        oa[3] = 8'hFF; ob[3] = 8'hFF; ov[3] = 1'b1; oc[3] = 2'd2;
        oa[4] = 8'h80; ob[4] = 8'h80; ov[4] = 1'b1; oc[4] = 2'd3;
        oa[5] = 8'hFF; ob[5] = 8'h01; ov[5] = 1'b1; oc[5] = 2'd3;
        oa[6] = 8'hFF; ob[6] = 8'hFF; ov[6] = 1'b1; oc[6] = 2'd3;
        oa[7] = 8'h01; ob[7] = 8'h01; ov[7] = 1'b1; oc[7] = 2'd3;
        @(negedge clk);
        rst_n = 1'b0;
        v8 = 1'b0;
        #1;
        total++;
        if (cc8 !== 2'd0) begin
            bad++;
            $display("FAIL cnt_reset: got %0d want 0", cc8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = ha_add(64'(oa[i]), 64'(ob[i]), 8);
            drive8(ov[i], oa[i], ob[i], {r.cout, r.sum[7:0]});
            if (ov[i]) begin
                expRes = q8.pop_front();
                total++;
                if ({c8, s8} !== expRes) begin
                    bad++;
                    $display("FAIL cnt_result[%0d]: got %h want %h", i, {c8, s8}, expRes);
                end
            end
            total++;
            if (cc8 !== oc[i]) begin
                bad++;
                $display("FAIL cnt_value[%0d]: got %0d want %0d", i, cc8, oc[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_width1();
        test_idle_hold();
        test_width8();
        test_async_reset();
        test_back_to_back();
`ifdef HALF_ADDER_CARRY_CNT_EN
        test_carry_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered, width-parameterised half adder: computes sum = a XOR b and cout = a AND b for WIDTH=1.
- For WIDTH>1 it computes the unsigned sum of a and b with a carry-in of 0: sum carries the low WIDTH bits, cout carries the carry-out.
- Leaf arithmetic block for adder/subtractor datapaths; one pipeline register stage with a valid qualifier.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).
- CNT_W, 16, width of the optional carry counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid this cycle
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- out_valid  output  1  sum/cout valid
- sum  output  WIDTH  registered result bits [WIDTH-1:0]
- cout  output  1  registered carry-out
- carry_count  output  CNT_W  number of accepted operations with cout=1 (present only with HALF_ADDER_CARRY_CNT_EN)

Behaviour:
- Reset:
  - Assertion of rst_n=0 clears out_valid, sum, cout (and carry_count) to 0 immediately, independent of clk.
  - Deassertion is synchronised by the integrator; the block samples normally on the first rising edge after rst_n=1.
- Arithmetic: {cout, sum} = zero-extended a + zero-extended b, computed in WIDTH+1 bits.
  - No carry-in.
  - No signed interpretation.
- WIDTH=1 truth table (a,b -> sum,cout): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Latency: exactly 1 cycle.
  - If in_valid=1 at rising edge N, sum/cout reflect that a/b after edge N.
  - out_valid=1 after edge N.
- in_valid=0 at an edge:
  - out_valid goes to 0.
  - sum and cout hold their previous values (no toggling on idle cycles).
- Back-to-back: a new operation is accepted every cycle; no backpressure, no ready signal.
- a/b are don't-care when in_valid=0; X on a/b while in_valid=0 must not propagate to sum/cout.
- Overflow boundary: a=b=2^WIDTH-1 -> sum=2^WIDTH-2, cout=1.
- Zero boundary: a=b=0 -> sum=0, cout=0.
- Reset mid-stream: outputs clear immediately; any operation presented in the same cycle as reset is discarded.
- The datapath is purely combinational into a single register stage; no FSM.

Optional Feature:
- Macro HALF_ADDER_CARRY_CNT_EN.
- When defined:
  - The carry_count port exists.
  - It increments by 1 on each rising edge where in_valid=1 and the computed cout=1.
  - It saturates at 2^CNT_W-1 (no wrap).
  - It resets to 0 on rst_n=0.
  - It updates in the same cycle as cout.
- When undefined:
  - The port and counter logic are absent.
  - Behaviour is otherwise identical.

Decomposition:
- Shared package half_adder_pkg:
  - constant HA_MAX_WIDTH=64.
  - typedef ha_result_t, a struct of {cout, sum} for a generic width via a localparam at use site.
  - function ha_add(a,b) returning the WIDTH+1 result for reuse by bench models.
- Sub-module half_adder_cell:
  - 1-bit combinational cell, s = x^y, c = x&y.
  - Instantiated for bit 0; higher bits use full-adder ripple or the + operator.
  - The cell is the natural leaf and is reused by the adder/subtractor.

Test Plan:
- WIDTH=1, reset then apply (a,b)=00,01,10,11 each held 20 time units with in_valid=1:
  - (sum,cout) one cycle later = (0,0),(1,0),(1,0),(0,1).
  - out_valid=1 throughout.
- WIDTH=8, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF -> sum=8'hFE, cout=1. Then a=8'h12, b=8'h34 -> sum=8'h46, cout=0.
- Idle hold: after a=1,b=1 result, drop in_valid for 3 cycles while a/b toggle:
  - out_valid=0.
  - sum=0, cout=1 held unchanged.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1:
  - out_valid, sum, cout = 0 before the next edge.
  - The first valid result appears 1 cycle after the first accepted post-reset operation.
- Back-to-back random: 1000 cycles of random a/b with random in_valid, compared against ha_add with 1-cycle delay:
  - Zero mismatches.
- With HALF_ADDER_CARRY_CNT_EN, CNT_W=2: five accepted operations producing cout=1 -> carry_count = 1,2,3,3,3 (saturates). Operations with cout=0 or in_valid=0 leave it unchanged.
